// File: rtl/layer1_pool_stage.sv
`default_nettype none
// ============================================================================
// layer1_pool_stage: 2x2 pooling of a layer-1 conv word, one group per cycle.
// Optional: LAYER1_POOL_AVG_EN selects average pooling instead of max pooling.
// Revision: 1.0
// ============================================================================
module layer1_pool_stage #(
  parameter int BITS         = 16,
  parameter int BITS_SHIFT   = 4,
  parameter int POOL_CHANNEL = 4,
  parameter int CHANNEL_NUM  = 4,
  parameter int POOL_WINDOW  = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                                                    clk_in,
  input  logic                                                    rst,
  input  logic [((POOL_CHANNEL*CHANNEL_NUM*POOL_WINDOW)<<BITS_SHIFT)-1:0] data_in,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  output logic [((POOL_CHANNEL*CHANNEL_NUM)<<BITS_SHIFT)-1:0]     data_out,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [CNT_BITS-1:0]                                     frame_cnt
);

  localparam int IN_W  = (POOL_CHANNEL*CHANNEL_NUM*POOL_WINDOW) << BITS_SHIFT;
  localparam int OUT_W = (POOL_CHANNEL*CHANNEL_NUM) << BITS_SHIFT;
  localparam int IN_IW  = $clog2(IN_W);
  localparam int OUT_IW = $clog2(OUT_W);
  localparam int GRP_W  = (POOL_CHANNEL > 1) ? $clog2(POOL_CHANNEL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [GRP_W-1:0]     grp_q, grp_d;
  logic [IN_W-1:0]      hold_q, hold_d;
  logic [OUT_W-1:0]     data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_BITS-1:0]  frame_cnt_q, frame_cnt_d;

  logic [CHANNEL_NUM*BITS-1:0] pooled;
  logic [OUT_IW-1:0]           out_base;

  // One shared comparator bank; grp_q steers which pool group it sees.
  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_bank
    logic [BITS-1:0] v [POOL_WINDOW];
    for (genvar t = 0; t < POOL_WINDOW; t++) begin : g_win
      logic [IN_IW-1:0] base;
      assign base = IN_IW'(((32'(grp_q) * CHANNEL_NUM + c) * POOL_WINDOW + t) << BITS_SHIFT);
      assign v[t] = hold_q[base +: BITS];
    end
`ifdef LAYER1_POOL_AVG_EN
    logic [BITS+1:0] sum;
    logic [BITS+1:0] avg;
    assign sum = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    assign avg = sum >> 2;
    assign pooled[c*BITS +: BITS] = avg[BITS-1:0];
`else
    logic [BITS-1:0] m_top, m_bot;
    assign m_top = (v[0] > v[1]) ? v[0] : v[1];
    assign m_bot = (v[2] > v[3]) ? v[2] : v[3];
    assign pooled[c*BITS +: BITS] = (m_top > m_bot) ? m_top : m_bot;
`endif
  end

  assign out_base = OUT_IW'((32'(grp_q) * CHANNEL_NUM) << BITS_SHIFT);

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = data_in;
          grp_d   = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        data_out_d[out_base +: CHANNEL_NUM*BITS] = pooled;
        grp_d = grp_q + 1'b1;
        if (grp_q == GRP_W'(POOL_CHANNEL-1)) begin
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        in_ready = out_ready;
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          out_valid_d = 1'b0;
          // Back-to-back: the freed output slot lets the next word in now.
          if (in_valid) begin
            hold_d  = data_in;
            grp_d   = '0;
            state_d = ST_CMP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grp_q       <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_layer1_pool_stage.sv
`default_nettype none
// ============================================================================
// tb_layer1_pool_stage: scoreboard bench for layer1_pool_stage (max or, with
// LAYER1_POOL_AVG_EN, average pooling).  Revision: 1.0
// ============================================================================
module tb_layer1_pool_stage;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   data_in;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  data_out;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OUT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  layer1_pool_stage dut (
    .clk_in    (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] pool_ref(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] r;
    logic [15:0] v, m;
    logic [17:0] s;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 4; c++) begin
        m = 16'h0;
        s = 18'h0;
        for (int k = 0; k < 4; k++) begin
          v = w[((g*16 + c*4 + k)*16) +: 16];
          if (v > m) m = v;
          s = s + {2'b00, v};
        end
`ifdef LAYER1_POOL_AVG_EN
        r[((g*4 + c)*16) +: 16] = s[17:2];
`else
        r[((g*4 + c)*16) +: 16] = m;
`endif
      end
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] set_win(input logic [IN_W-1:0] w, input int g, input int c,
                                               input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] d, input logic [15:0] e);
    logic [IN_W-1:0] r;
    int base;
    r = w;
    base = (g*16 + c*4) * 16;
    r[base +: 16]      = a;
    r[base + 16 +: 16] = b;
    r[base + 32 +: 16] = d;
    r[base + 48 +: 16] = e;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive a word (in_ready expected high now) and take it on the next edge.
  task automatic accept_word(input string tag, input logic [IN_W-1:0] w, input bit push);
    data_in  = w;
    in_valid = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, OUT_W'(in_ready), OUT_W'(1));
    @(posedge clk);
    if (push) exp_q.push_back(pool_ref(w));
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid rises (bounded).
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    check_eq({tag, "_latency"}, OUT_W'(n), OUT_W'(4));
  endtask

  task automatic compare_head(input string tag);
    check_eq({tag, "_sb_depth"}, OUT_W'(exp_q.size()), OUT_W'(1));
    if (exp_q.size() > 0) check_eq({tag, "_data"}, data_out, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]  w;
    logic [OUT_W-1:0] e, snap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
    check_eq("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check_eq("rst_data_out",  data_out,          '0);
    check_eq("rst_frame_cnt", OUT_W'(frame_cnt), OUT_W'(0));

    // Single word with a known winner per window.
    out_ready = 1'b1;
    w = '0;
    e = '0;
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++) begin
        w = set_win(w, g, c, 16'(g*16 + c), 16'(16'h0100 + c), 16'h0005, 16'(16'h7FFF - g));
`ifdef LAYER1_POOL_AVG_EN
        e[((g*4 + c)*16) +: 16] = 16'((g*16 + c + 256 + c + 5 + 32767 - g) >> 2);
`else
        e[((g*4 + c)*16) +: 16] = 16'(16'h7FFF - g);
`endif
      end
    accept_word("tp", w, 1'b1);
    wait_out("tp");
    check_eq("tp_slices", data_out, e);
    compare_head("tp");
    @(posedge clk);
    #1;
    check_eq("tp_out_valid_drop", OUT_W'(out_valid), OUT_W'(0));
    check_eq("tp_frame_cnt",      OUT_W'(frame_cnt), OUT_W'(1));
    check_eq("tp_idle_ready",     OUT_W'(in_ready),  OUT_W'(1));

    // Backpressure, then back-to-back accept on the releasing handshake.
    out_ready = 1'b0;
    accept_word("bp", rand_word(), 1'b1);
    wait_out("bp");
    snap = data_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_valid", OUT_W'(out_valid), OUT_W'(1));
      check_eq("bp_hold_data",  data_out,          snap);
      check_eq("bp_hold_ready", OUT_W'(in_ready),  OUT_W'(0));
    end
    check_eq("bp_hold_cnt", OUT_W'(frame_cnt), OUT_W'(1));
    compare_head("bp");
    w = rand_word();
    out_ready = 1'b1;
    accept_word("b2b", w, 1'b1);
    check_eq("b2b_frame_cnt", OUT_W'(frame_cnt), OUT_W'(2));
    check_eq("b2b_out_valid", OUT_W'(out_valid), OUT_W'(0));
    wait_out("b2b");
    compare_head("b2b");
    @(posedge clk);
    #1;
    check_eq("b2b_frame_cnt2", OUT_W'(frame_cnt), OUT_W'(3));

    // Reset during the second compare cycle discards the word.
    accept_word("mid", rand_word(), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
    check_eq("mid_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check_eq("mid_data_out",  data_out,          '0);
    check_eq("mid_frame_cnt", OUT_W'(frame_cnt), OUT_W'(0));
    accept_word("fresh", rand_word(), 1'b1);
    wait_out("fresh");
    compare_head("fresh");
    @(posedge clk);
    #1;
    check_eq("fresh_frame_cnt", OUT_W'(frame_cnt), OUT_W'(1));

    // Counter wrap with an all-equal word (ties).
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    #1;
    check_eq("wrap_preload", OUT_W'(frame_cnt), OUT_W'(16'hFFFF));
    w = '0;
    for (int i = 0; i < 64; i++) w[i*16 +: 16] = 16'h1234;
    accept_word("tie", w, 1'b1);
    wait_out("tie");
    e = '0;
    for (int i = 0; i < 16; i++) e[i*16 +: 16] = 16'h1234;
    check_eq("tie_slices", data_out, e);
    compare_head("tie");
    @(posedge clk);
    #1;
    check_eq("wrap_frame_cnt", OUT_W'(frame_cnt), OUT_W'(0));

    // Saturated and small windows; even channels vs odd channels.
    w = '0;
    e = '0;
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++) begin
        if (c % 2 == 0) begin
          w = set_win(w, g, c, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD);
`ifdef LAYER1_POOL_AVG_EN
          e[((g*4 + c)*16) +: 16] = 16'hFFFE;
`else
          e[((g*4 + c)*16) +: 16] = 16'hFFFF;
`endif
        end else begin
          w = set_win(w, g, c, 16'h0001, 16'h0002, 16'h0003, 16'h0003);
`ifdef LAYER1_POOL_AVG_EN
          e[((g*4 + c)*16) +: 16] = 16'h0002;
`else
          e[((g*4 + c)*16) +: 16] = 16'h0003;
`endif
        end
      end
    accept_word("edge", w, 1'b1);
    wait_out("edge");
    check_eq("edge_slices", data_out, e);
    compare_head("edge");
    @(posedge clk);
    #1;
    check_eq("edge_frame_cnt", OUT_W'(frame_cnt), OUT_W'(1));

    // Random words, always-ready sink.
    for (int k = 0; k < 4; k++) begin
      accept_word("rnd", rand_word(), 1'b1);
      wait_out("rnd");
      compare_head("rnd");
      @(posedge clk);
      #1;
    end
    check_eq("rnd_frame_cnt", OUT_W'(frame_cnt), OUT_W'(5));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
